// File: rtl/cacheline_arbiter_pkg.sv
// Shared types for the cacheline arbiter: FSM states, requester ids and
// default line/address widths.
package cacheline_arbiter_pkg;

  localparam int LINE_W_DEF = 256;
  localparam int ADDR_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

  function automatic req_id_t other_req(input req_id_t r);
    return (r == REQ_I) ? REQ_D : REQ_I;
  endfunction

endpackage

// File: rtl/cacheline_arbiter_if.sv
// Bundle of the I-cache, D-cache and physical-memory cacheline signals.
// slave is the arbiter's view; master is the caches-plus-adaptor view.
interface cacheline_arbiter_if
  import cacheline_arbiter_pkg::*;
#(
  parameter int LINE_W = LINE_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata,
           pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp,
           pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata,
           pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp,
           pmem_read, pmem_write, pmem_address, pmem_wdata
  );

endinterface

// File: rtl/cacheline_arbiter_pick.sv
// Combinational tie-break between two line requesters; FAIR alternates
// against the previous grant, otherwise the D side wins ties.
module arb_pick
  import cacheline_arbiter_pkg::*;
#(
  parameter int FAIR = 1
) (
  input  logic    i_req,
  input  logic    d_req,
  input  req_id_t last_grant,
  output logic    gnt_vld,
  output req_id_t gnt_id
);

  always_comb begin
    gnt_vld = i_req | d_req;
    gnt_id  = REQ_D;
    if (i_req && d_req) begin
      gnt_id = (FAIR != 0) ? other_req(last_grant) : REQ_D;
    end else if (i_req) begin
      gnt_id = REQ_I;
    end
  end

endmodule

// File: rtl/cacheline_arbiter.sv
// Serialises I-cache and D-cache line transactions onto one physical-memory
// port, with a registered downstream request and a one-cycle resp to the owner.
module cacheline_arbiter
  import cacheline_arbiter_pkg::*;
#(
  parameter int LINE_W = LINE_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int FAIR   = 1
) (
  input  logic                clk,
  input  logic                rst,
  cacheline_arbiter_if.slave  bus
);

  arb_state_t        state_q, state_d;
  req_id_t           last_grant_q, last_grant_d;
  logic              pmem_read_q, pmem_read_d;
  logic              pmem_write_q, pmem_write_d;
  logic [ADDR_W-1:0] pmem_address_q, pmem_address_d;
  logic [LINE_W-1:0] pmem_wdata_q, pmem_wdata_d;

  logic    d_req;
  logic    gnt_vld;
  req_id_t gnt_id;
  logic    i_resp_c, d_resp_c;

  assign d_req = bus.d_read | bus.d_write;

  arb_pick #(.FAIR(FAIR)) u_pick (
    .i_req      (bus.i_read),
    .d_req      (d_req),
    .last_grant (last_grant_q),
    .gnt_vld    (gnt_vld),
    .gnt_id     (gnt_id)
  );

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    pmem_read_d    = pmem_read_q;
    pmem_write_d   = pmem_write_q;
    pmem_address_d = pmem_address_q;
    pmem_wdata_d   = pmem_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          last_grant_d = gnt_id;
          if (gnt_id == REQ_I) begin
            state_d        = SERVE_I;
            pmem_read_d    = 1'b1;
            pmem_write_d   = 1'b0;
            pmem_address_d = bus.i_address;
          end else begin
            // A writeback wins over a simultaneous read from the D side.
            state_d        = SERVE_D;
            pmem_read_d    = bus.d_read & ~bus.d_write;
            pmem_write_d   = bus.d_write;
            pmem_address_d = bus.d_address;
            pmem_wdata_d   = bus.d_wdata;
          end
        end
      end
      SERVE_I, SERVE_D: begin
        // Always return through IDLE so a stale level request is re-arbitrated.
        if (bus.pmem_resp) begin
          state_d      = IDLE;
          pmem_read_d  = 1'b0;
          pmem_write_d = 1'b0;
        end
      end
      default: begin
        state_d      = IDLE;
        pmem_read_d  = 1'b0;
        pmem_write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      last_grant_q   <= REQ_D;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      pmem_read_q    <= pmem_read_d;
      pmem_write_q   <= pmem_write_d;
      pmem_address_q <= pmem_address_d;
      pmem_wdata_q   <= pmem_wdata_d;
    end
  end

  assign i_resp_c = (state_q == SERVE_I) & bus.pmem_resp;
  assign d_resp_c = (state_q == SERVE_D) & bus.pmem_resp;

  assign bus.i_resp       = i_resp_c;
  assign bus.d_resp       = d_resp_c;
  assign bus.i_rdata      = i_resp_c ? bus.pmem_rdata : '0;
  assign bus.d_rdata      = d_resp_c ? bus.pmem_rdata : '0;
  assign bus.pmem_read    = pmem_read_q;
  assign bus.pmem_write   = pmem_write_q;
  assign bus.pmem_address = pmem_address_q;
  assign bus.pmem_wdata   = pmem_wdata_q;

  always @(posedge clk) begin
    if (rst && state_q == IDLE) begin
      assert (!(bus.d_read && bus.d_write))
        else $warning("cacheline_arbiter: d_read and d_write both high, write wins");
    end
  end

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Bench for cacheline_arbiter: two instances (bus 0 uses FAIR=0, bus 1 FAIR=1)
// driven by directed and randomized transactions against a grant model.
module tb_cacheline_arbiter;

  logic clk;
  logic rst;

  logic         i_read_a     [2];
  logic [31:0]  i_addr_a     [2];
  logic         d_read_a     [2];
  logic         d_write_a    [2];
  logic [31:0]  d_addr_a     [2];
  logic [255:0] d_wdata_a    [2];
  logic [255:0] pmem_rdata_a [2];
  logic         pmem_resp_a  [2];

  logic         i_resp_a     [2];
  logic [255:0] i_rdata_a    [2];
  logic         d_resp_a     [2];
  logic [255:0] d_rdata_a    [2];
  logic         pmem_read_a  [2];
  logic         pmem_write_a [2];
  logic [31:0]  pmem_addr_a  [2];
  logic [255:0] pmem_wdata_a [2];

  int n_cmp;
  int n_bad;
  int lg [2];

  for (genvar k = 0; k < 2; k++) begin : g
    cacheline_arbiter_if #(.LINE_W(256), .ADDR_W(32)) bus ();

    cacheline_arbiter #(.LINE_W(256), .ADDR_W(32), .FAIR(k)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    assign bus.i_read     = i_read_a[k];
    assign bus.i_address  = i_addr_a[k];
    assign bus.d_read     = d_read_a[k];
    assign bus.d_write    = d_write_a[k];
    assign bus.d_address  = d_addr_a[k];
    assign bus.d_wdata    = d_wdata_a[k];
    assign bus.pmem_rdata = pmem_rdata_a[k];
    assign bus.pmem_resp  = pmem_resp_a[k];

    assign i_resp_a[k]     = bus.i_resp;
    assign i_rdata_a[k]    = bus.i_rdata;
    assign d_resp_a[k]     = bus.d_resp;
    assign d_rdata_a[k]    = bus.d_rdata;
    assign pmem_read_a[k]  = bus.pmem_read;
    assign pmem_write_a[k] = bus.pmem_write;
    assign pmem_addr_a[k]  = bus.pmem_address;
    assign pmem_wdata_a[k] = bus.pmem_wdata;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int k,
                       input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_bad++;
        $error("FAIL %s bus%0d: observed %0h expected %0h", tag, k, obs, exp);
      end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // One complete transaction on bus k; the owner is predicted from the request
  // levels, the bus's tie rule and the previous owner (0 = I, 1 = D).
  task automatic serve(input int k, input int lat, input bit drop_mid,
                       input bit drop_end, input logic [255:0] rd);
    int own;
    int waited;
    bit ir, dr, exp_wr;
    logic [31:0]  ea;
    logic [255:0] ew;
    ir = i_read_a[k];
    dr = d_read_a[k] | d_write_a[k];
    if (ir && dr) own = (k == 1) ? ((lg[k] == 0) ? 1 : 0) : 1;
    else          own = ir ? 0 : 1;
    ea     = (own == 0) ? i_addr_a[k] : d_addr_a[k];
    ew     = d_wdata_a[k];
    exp_wr = (own == 1) && d_write_a[k];

    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!(pmem_read_a[k] | pmem_write_a[k]) && waited < 3);
    check("grant_latency", k, 256'(waited), 256'(1));
    if (!(pmem_read_a[k] | pmem_write_a[k])) return;
    lg[k] = own;

    check("pmem_read", k, 256'(pmem_read_a[k]), 256'(!exp_wr));
    check("pmem_write", k, 256'(pmem_write_a[k]), 256'(exp_wr));
    check("pmem_address", k, 256'(pmem_addr_a[k]), 256'(ea));
    if (exp_wr) check("pmem_wdata", k, pmem_wdata_a[k], ew);

    for (int c = 0; c < lat; c++) begin
      if (drop_mid && c == 1) begin
        if (own == 0) i_read_a[k] = 1'b0;
        else begin d_read_a[k] = 1'b0; d_write_a[k] = 1'b0; end
      end
      i_addr_a[k]  = $urandom();
      d_addr_a[k]  = $urandom();
      d_wdata_a[k] = rand_line();
      @(negedge clk);
      check("hold_address", k, 256'(pmem_addr_a[k]), 256'(ea));
      check("hold_write", k, 256'(pmem_write_a[k]), 256'(exp_wr));
      check("early_resp", k, 256'({i_resp_a[k], d_resp_a[k]}), 256'(0));
    end

    pmem_resp_a[k]  = 1'b1;
    pmem_rdata_a[k] = rd;
    #1;
    check("owner_resp", k, 256'(own == 0 ? i_resp_a[k] : d_resp_a[k]), 256'(1));
    check("owner_rdata", k, own == 0 ? i_rdata_a[k] : d_rdata_a[k], rd);
    check("other_resp", k, 256'(own == 0 ? d_resp_a[k] : i_resp_a[k]), 256'(0));
    check("other_rdata", k, own == 0 ? d_rdata_a[k] : i_rdata_a[k], 256'(0));
    if (drop_end) begin
      if (own == 0) i_read_a[k] = 1'b0;
      else begin d_read_a[k] = 1'b0; d_write_a[k] = 1'b0; end
    end

    @(negedge clk);
    pmem_resp_a[k]  = 1'b0;
    pmem_rdata_a[k] = '0;
    #1;
    check("idle_gap", k, 256'({pmem_read_a[k], pmem_write_a[k]}), 256'(0));
    check("idle_resp", k, 256'({i_resp_a[k], d_resp_a[k]}), 256'(0));
  endtask

  task automatic clear_req(input int k);
    i_read_a[k]  = 1'b0;
    d_read_a[k]  = 1'b0;
    d_write_a[k] = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b0;
    for (int k = 0; k < 2; k++) begin
      i_read_a[k]     = 1'b1;
      i_addr_a[k]     = 32'h0000_0040;
      d_read_a[k]     = 1'b0;
      d_write_a[k]    = 1'b1;
      d_addr_a[k]     = 32'h8000_0000;
      d_wdata_a[k]    = rand_line();
      pmem_rdata_a[k] = '0;
      pmem_resp_a[k]  = 1'b0;
      lg[k]           = 1;
    end

    // Reset held with requests pending.
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst_pmem_rw", k, 256'({pmem_read_a[k], pmem_write_a[k]}), 256'(0));
      check("rst_pmem_addr", k, 256'(pmem_addr_a[k]), 256'(0));
      check("rst_pmem_wdata", k, pmem_wdata_a[k], 256'(0));
      check("rst_resp", k, 256'({i_resp_a[k], d_resp_a[k]}), 256'(0));
    end
    rst = 1'b1;

    // Continuous tie: FAIR bus alternates starting with I, bus 0 always D.
    for (int t = 0; t < 4; t++) serve(1, 1 + t, 1'b0, 1'b0, rand_line());
    clear_req(1);
    for (int t = 0; t < 4; t++) serve(0, 2, 1'b0, 1'b0, rand_line());
    clear_req(0);

    // Lone I read.
    i_read_a[1] = 1'b1;
    i_addr_a[1] = 32'h0000_0040;
    serve(1, 5, 1'b0, 1'b1, {32{8'hA5}});

    // Lone D writeback and lone D read.
    d_write_a[1] = 1'b1;
    d_addr_a[1]  = 32'h8000_0000;
    d_wdata_a[1] = {8{32'hDEAD_BEEF}};
    serve(1, 3, 1'b0, 1'b1, rand_line());
    d_read_a[1] = 1'b1;
    d_addr_a[1] = 32'h1234_5680;
    serve(1, 2, 1'b0, 1'b1, rand_line());

    // Requester drops its request mid-transaction.
    i_read_a[1] = 1'b1;
    i_addr_a[1] = 32'h0000_1000;
    serve(1, 4, 1'b1, 1'b0, rand_line());

    // Spurious pmem_resp while idle.
    pmem_resp_a[1]  = 1'b1;
    pmem_rdata_a[1] = rand_line();
    #1;
    check("spur_resp", 1, 256'({i_resp_a[1], d_resp_a[1]}), 256'(0));
    check("spur_irdata", 1, i_rdata_a[1], 256'(0));
    check("spur_drdata", 1, d_rdata_a[1], 256'(0));
    @(negedge clk);
    pmem_resp_a[1] = 1'b0;
    check("spur_pmem", 1, 256'({pmem_read_a[1], pmem_write_a[1]}), 256'(0));

    // Asynchronous reset in the middle of a D writeback.
    d_write_a[1] = 1'b1;
    d_addr_a[1]  = 32'hC000_0000;
    @(negedge clk);
    check("mid_grant", 1, 256'(pmem_write_a[1]), 256'(1));
    clear_req(1);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_write", 1, 256'(pmem_write_a[1]), 256'(0));
    check("mid_rst_addr", 1, 256'(pmem_addr_a[1]), 256'(0));
    pmem_resp_a[1] = 1'b1;
    #1;
    check("mid_rst_resp", 1, 256'(d_resp_a[1]), 256'(0));
    @(negedge clk);
    pmem_resp_a[1] = 1'b0;
    rst   = 1'b1;
    lg[0] = 1;
    lg[1] = 1;

    // Randomized traffic on both buses.
    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 30; n++) begin
        int dsel;
        int lat;
        i_read_a[k]  = 1'($urandom_range(1));
        dsel         = $urandom_range(2);
        d_read_a[k]  = (dsel == 1);
        d_write_a[k] = (dsel == 2);
        if (dsel == 0) i_read_a[k] = 1'b1;
        i_addr_a[k]  = $urandom();
        d_addr_a[k]  = $urandom();
        d_wdata_a[k] = rand_line();
        lat          = $urandom_range(5);
        serve(k, lat, (lat >= 2) && ($urandom_range(3) == 0),
              1'($urandom_range(1)), rand_line());
      end
      clear_req(k);
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
